// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared constants and types for the instruction fetch stage:
//     INSTR_W       instruction word width (16)
//     PC_W_DEFAULT  default word-address width (12, matches the J-type target)
//     OP_J          opcode [15:12] of the unconditional jump
//     fetch_state_e fetch FSM state encoding (FS_BOOT/FS_IDLE/FS_WAIT/FS_FLUSH)
//     is_jump_op()  opcode test used by the optional jump predecoder
//   Optional feature macro used by instruction_fetch: FETCH_JUMP_PREDECODE_EN
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int         INSTR_W      = 16;
    localparam int         PC_W_DEFAULT = 12;
    localparam logic [3:0] OP_J         = 4'b1100;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_IDLE  = 2'd1,
        FS_WAIT  = 2'd2,
        FS_FLUSH = 2'd3
    } fetch_state_e;

    function automatic logic is_jump_op(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OP_J;
    endfunction

endpackage

// File: rtl/instruction_fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// instruction_fetch_skid_buf
//   Output slot plus one-entry pending buffer between instruction memory and
//   the decode stage.
//   Ports:
//     clk_i, rst_i          clock, asynchronous active-high reset
//     flush_i               drop both slot and pending entry (redirect)
//     load_i                a memory response is presented this cycle
//     load_instr_i/pc_i     the response word and its fetch address
//     id_ready_i            decoder accepts the slot this cycle
//     to_slot_o             a response loaded now lands directly in the slot
//     pend_valid_o          pending entry is occupied
//     id_valid_o/instr_o/pc_o  slot contents presented to decode
//   Handshake: the slot is transferred on an edge where id_valid_o=1 and
//   id_ready_i=1; while id_valid_o=1 and id_ready_i=0 the slot is held stable.
// -----------------------------------------------------------------------------
module instruction_fetch_skid_buf
    import instruction_fetch_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    input  logic [PC_W-1:0]    load_pc_i,
    input  logic               id_ready_i,
    output logic               to_slot_o,
    output logic               pend_valid_o,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [PC_W-1:0]    id_pc_o
);

    logic               slot_valid_q, slot_valid_d;
    logic [INSTR_W-1:0] slot_instr_q, slot_instr_d;
    logic [PC_W-1:0]    slot_pc_q,    slot_pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
    logic [PC_W-1:0]    pend_pc_q,    pend_pc_d;
    logic               slot_free;

    // Slot can take new data if it is empty or being consumed this cycle.
    assign slot_free = !slot_valid_q || id_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_instr_q <= '0;
            pend_pc_q    <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_instr_q <= pend_instr_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        pend_valid_d = pend_valid_q;
        pend_instr_d = pend_instr_q;
        pend_pc_d    = pend_pc_q;
        if (flush_i) begin
            // Data registers keep their contents; only the valids matter.
            slot_valid_d = 1'b0;
            pend_valid_d = 1'b0;
        end else if (slot_free) begin
            if (pend_valid_q) begin
                // Older pending entry goes first; a same-cycle response refills pend.
                slot_valid_d = 1'b1;
                slot_instr_d = pend_instr_q;
                slot_pc_d    = pend_pc_q;
                pend_valid_d = load_i;
                if (load_i) begin
                    pend_instr_d = load_instr_i;
                    pend_pc_d    = load_pc_i;
                end
            end else if (load_i) begin
                slot_valid_d = 1'b1;
                slot_instr_d = load_instr_i;
                slot_pc_d    = load_pc_i;
            end else begin
                slot_valid_d = 1'b0;
            end
        end else if (load_i && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_instr_d = load_instr_i;
            pend_pc_d    = load_pc_i;
        end
    end

    assign to_slot_o    = slot_free && !pend_valid_q;
    assign pend_valid_o = pend_valid_q;
    assign id_valid_o   = slot_valid_q;
    assign id_instr_o   = slot_instr_q;
    assign id_pc_o      = slot_pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: holds the PC, issues single-outstanding word reads to
//   instruction memory and hands {id_instr_o, id_pc_o} to decode.
//   Optional feature: FETCH_JUMP_PREDECODE_EN -- when defined, a response whose
//   opcode is OP_J moves the PC to its 12-bit target and the next request is
//   issued from there; the J instruction itself is still delivered.
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     imem_req_o/addr_o       one-cycle read request; address valid with req
//     imem_rdata_i/valid_i    read response, >=1 cycle after the request
//     redirect_valid_i/pc_i   restart fetch at redirect_pc_i
//     id_valid_o/instr_o/pc_o instruction slot to decode
//     id_ready_i              decode accepts the slot
//     dbg_state_o             current FSM state
//     dbg_pend_valid_o        pending (skid) entry occupied
//   Handshake: decode takes the slot on an edge where id_valid_o=1 and
//   id_ready_i=1; a redirect on the same edge clears the slot regardless.
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               imem_valid_i,
    input  logic               redirect_valid_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [PC_W-1:0]    id_pc_o,
    input  logic               id_ready_i,
    output fetch_state_e       dbg_state_o,
    output logic               dbg_pend_valid_o
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q;       // address of the outstanding request
    logic            issue;
    logic            rsp_accept;     // response kept (not stale, not redirected)
    logic            rsp_is_jump;
    logic [PC_W-1:0] jump_target;
    logic            back_to_back;
    logic            to_slot;
    logic            pend_valid;

    assign rsp_accept = (state_q == FS_WAIT) && imem_valid_i && !redirect_valid_i;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign rsp_is_jump = rsp_accept && is_jump_op(imem_rdata_i);
    assign jump_target = PC_W'(imem_rdata_i[11:0]);
`else
    assign rsp_is_jump = 1'b0;
    assign jump_target = pc_q;
`endif

    // Next request in the same cycle as a response, only if the response did
    // not have to park in pend and did not change the fetch direction.
    assign back_to_back = rsp_accept && to_slot && !rsp_is_jump;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= FS_BOOT;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if (issue) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_BOOT:  state_d = FS_IDLE;
            FS_IDLE:  if (!redirect_valid_i && !pend_valid) state_d = FS_WAIT;
            FS_WAIT: begin
                if (redirect_valid_i) begin
                    state_d = imem_valid_i ? FS_IDLE : FS_FLUSH;
                end else if (imem_valid_i) begin
                    state_d = back_to_back ? FS_WAIT : FS_IDLE;
                end
            end
            // The stale response ends the flush even if another redirect
            // arrives with it; nothing else is outstanding to wait for.
            FS_FLUSH: if (imem_valid_i) state_d = FS_IDLE;
            default:  state_d = FS_BOOT;
        endcase

        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (rsp_is_jump) begin
            pc_d = jump_target;
        end else if (issue) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // Output logic
    always_comb begin
        issue = 1'b0;
        case (state_q)
            FS_IDLE: issue = !redirect_valid_i && !pend_valid;
            FS_WAIT: issue = back_to_back;
            default: issue = 1'b0;
        endcase
        imem_req_o  = issue;
        imem_addr_o = issue ? pc_q : '0;
    end

    instruction_fetch_skid_buf #(
        .PC_W (PC_W)
    ) u_skid (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_valid_i),
        .load_i       (rsp_accept),
        .load_instr_i (imem_rdata_i),
        .load_pc_i    (req_pc_q),
        .id_ready_i   (id_ready_i),
        .to_slot_o    (to_slot),
        .pend_valid_o (pend_valid),
        .id_valid_o   (id_valid_o),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o)
    );

    assign dbg_state_o      = state_q;
    assign dbg_pend_valid_o = pend_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. Memory model: 1-cycle latency,
//   mem[a] = {4'h0, a}, except mem[3] = 16'hC100 once jump_mode is set.
//   Expected delivery order is kept in exp_q.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic         imem_req;
    logic [11:0]  imem_addr;
    logic [15:0]  imem_rdata = '0;
    logic         imem_valid = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [11:0]  redirect_pc = '0;
    logic         id_valid;
    logic [15:0]  id_instr;
    logic [11:0]  id_pc;
    logic         id_ready = 1'b0;
    fetch_state_e dbg_state;
    logic         dbg_pend_valid;

    instruction_fetch #(
        .PC_W     (12),
        .RESET_PC (12'h000)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .imem_valid_i     (imem_valid),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .id_valid_o       (id_valid),
        .id_instr_o       (id_instr),
        .id_pc_o          (id_pc),
        .id_ready_i       (id_ready),
        .dbg_state_o      (dbg_state),
        .dbg_pend_valid_o (dbg_pend_valid)
    );

    // Memory model state
    logic        mem_pend = 1'b0;
    logic [11:0] mem_pend_addr = '0;
    logic        jump_mode = 1'b0;

    // Values sampled mid-cycle by step()
    logic         s_req, s_idv, s_pend;
    logic [11:0]  s_addr, s_pc;
    logic [15:0]  s_instr;
    fetch_state_e s_st;

    // Scoreboard
    logic [27:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        if (jump_mode && a == 12'h003) return 16'hC100;
        return {4'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample mid-cycle,
    // advance the memory model, score any handshake, wait for the next edge.
    task automatic step(input logic rv, input logic [11:0] rpc, input logic rdy, input logic hold);
        logic [27:0] e;
        if (mem_pend && !hold) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(mem_pend_addr);
            mem_pend   = 1'b0;
        end else begin
            imem_valid = 1'b0;
            imem_rdata = '0;
        end
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #2;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_idv   = id_valid;
        s_instr = id_instr;
        s_pc    = id_pc;
        s_st    = dbg_state;
        s_pend  = dbg_pend_valid;
        if (imem_req) begin
            mem_pend      = 1'b1;
            mem_pend_addr = imem_addr;
        end
        if (s_idv && rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_extra observed=%0h expected=none", {s_instr, s_pc});
            end else begin
                e = exp_q.pop_front();
                chk("sb_deliver", 32'({s_instr, s_pc}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_q.push_back({16'h0000, 12'h000});
        exp_q.push_back({16'h0001, 12'h001});
        exp_q.push_back({16'h0002, 12'h002});
        exp_q.push_back({16'h0003, 12'h003});
        exp_q.push_back({16'h0004, 12'h004});
        exp_q.push_back({16'h0100, 12'h100});
        exp_q.push_back({16'h0FFE, 12'hFFE});
        exp_q.push_back({16'h0FFF, 12'hFFF});
        exp_q.push_back({16'h0000, 12'h000});
        exp_q.push_back({16'h0001, 12'h001});
        exp_q.push_back({16'h0002, 12'h002});
        exp_q.push_back({16'hC100, 12'h003});

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(dbg_state), 32'(FS_BOOT));
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_idv", 32'(id_valid), 32'd0);
        chk("rst_instr", 32'(id_instr), 32'd0);
        chk("rst_pc", 32'(id_pc), 32'd0);
        chk("rst_pend", 32'(dbg_pend_valid), 32'd0);
        rst = 1'b0;

        // Streaming from reset, id_ready=1
        step(1'b0, 12'h0, 1'b1, 1'b0); // BOOT
        chk("boot_req", 32'(s_req), 32'd0);
        chk("boot_state", 32'(s_st), 32'(FS_BOOT));
        step(1'b0, 12'h0, 1'b1, 1'b0); // IDLE, fetch 0
        chk("c2_req", 32'(s_req), 32'd1);
        chk("c2_addr", 32'(s_addr), 32'h000);
        chk("c2_state", 32'(s_st), 32'(FS_IDLE));
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("c3_req", 32'(s_req), 32'd1);
        chk("c3_addr", 32'(s_addr), 32'h001);
        chk("c3_idv", 32'(s_idv), 32'd0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("c4_addr", 32'(s_addr), 32'h002);
        chk("c4_idv", 32'(s_idv), 32'd1);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("c5_addr", 32'(s_addr), 32'h003);

        // Stall decode for 3 cycles while id_pc=2
        step(1'b0, 12'h0, 1'b0, 1'b0);
        chk("stall1_req", 32'(s_req), 32'd0);
        chk("stall1_instr", 32'(s_instr), 32'h0002);
        step(1'b0, 12'h0, 1'b0, 1'b0);
        chk("stall2_req", 32'(s_req), 32'd0);
        chk("stall2_pc", 32'(s_pc), 32'h002);
        chk("stall2_pend", 32'(s_pend), 32'd1);
        chk("stall2_state", 32'(s_st), 32'(FS_IDLE));
        step(1'b0, 12'h0, 1'b0, 1'b0);
        chk("stall3_req", 32'(s_req), 32'd0);
        chk("stall3_instr", 32'(s_instr), 32'h0002);
        step(1'b0, 12'h0, 1'b1, 1'b0); // release: 2 taken, pend -> slot
        chk("rel1_req", 32'(s_req), 32'd0);
        chk("rel1_pend", 32'(s_pend), 32'd1);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("rel2_req", 32'(s_req), 32'd1);
        chk("rel2_addr", 32'(s_addr), 32'h004);
        chk("rel2_pend", 32'(s_pend), 32'd0);
        chk("rel2_instr", 32'(s_instr), 32'h0003);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("rel3_addr", 32'(s_addr), 32'h005);
        chk("rel3_idv", 32'(s_idv), 32'd0);

        // Redirect to 0x100 while the request for 5 is outstanding
        step(1'b1, 12'h100, 1'b1, 1'b1);
        chk("flush_req", 32'(s_req), 32'd0);
        chk("flush_instr", 32'(s_instr), 32'h0004);
        step(1'b0, 12'h0, 1'b1, 1'b0); // stale response for 5 arrives
        chk("flush_idv", 32'(s_idv), 32'd0);
        chk("flush_req2", 32'(s_req), 32'd0);
        chk("flush_state", 32'(s_st), 32'(FS_FLUSH));
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("redir_req", 32'(s_req), 32'd1);
        chk("redir_addr", 32'(s_addr), 32'h100);
        chk("redir_idv", 32'(s_idv), 32'd0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("redir_addr2", 32'(s_addr), 32'h101);

        // Redirect together with imem_valid and id_ready
        step(1'b1, 12'hFFE, 1'b1, 1'b0);
        chk("same_req", 32'(s_req), 32'd0);
        chk("same_instr", 32'(s_instr), 32'h0100);
        chk("same_state", 32'(s_st), 32'(FS_WAIT));
        jump_mode = 1'b1;
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("same_idv", 32'(s_idv), 32'd0);
        chk("wrap_addr0", 32'(s_addr), 32'hFFE);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("wrap_addr1", 32'(s_addr), 32'hFFF);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("wrap_addr2", 32'(s_addr), 32'h000);
        chk("wrap_pc0", 32'(s_pc), 32'hFFE);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("wrap_addr3", 32'(s_addr), 32'h001);
        chk("wrap_pc1", 32'(s_pc), 32'hFFF);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("wrap_addr4", 32'(s_addr), 32'h002);
        chk("wrap_pc2", 32'(s_pc), 32'h000);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("j_addr3", 32'(s_addr), 32'h003);

        // mem[3] is a J to 0x100
        step(1'b0, 12'h0, 1'b1, 1'b0); // J response arrives
`ifdef FETCH_JUMP_PREDECODE_EN
        chk("j_resp_req", 32'(s_req), 32'd0);
`else
        chk("j_resp_req", 32'(s_req), 32'd1);
        chk("j_resp_addr", 32'(s_addr), 32'h004);
`endif
        step(1'b0, 12'h0, 1'b1, 1'b0); // J delivered
        chk("j_instr", 32'(s_instr), 32'hC100);
        chk("j_pc", 32'(s_pc), 32'h003);
        chk("j_next_req", 32'(s_req), 32'd1);
`ifdef FETCH_JUMP_PREDECODE_EN
        chk("j_next_addr", 32'(s_addr), 32'h100);
`else
        chk("j_next_addr", 32'(s_addr), 32'h005);
`endif

        // Reset while a request is in flight
        rst = 1'b1;
        #1;
        chk("mrst_state", 32'(dbg_state), 32'(FS_BOOT));
        chk("mrst_idv", 32'(id_valid), 32'd0);
        chk("mrst_req", 32'(imem_req), 32'd0);
        step(1'b0, 12'h0, 1'b1, 1'b0); // in-flight response arrives under reset
        chk("mrst_req2", 32'(s_req), 32'd0);
        chk("mrst_idv2", 32'(s_idv), 32'd0);
        rst = 1'b0;
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("mrst_boot", 32'(s_st), 32'(FS_BOOT));
        chk("mrst_boot_req", 32'(s_req), 32'd0);
        chk("mrst_boot_idv", 32'(s_idv), 32'd0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        chk("mrst_first_req", 32'(s_req), 32'd1);
        chk("mrst_first_addr", 32'(s_addr), 32'h000);

        chk("sb_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
